// File: rtl/rf_wb_pkg.sv
// Shared types, constants and helpers for the register-file writeback arbiter.
package rf_wb_pkg;

    localparam int unsigned RF_WIDTH    = 64;
    localparam int unsigned RF_LG_DEPTH = 6;
    localparam int unsigned RF_N_REQ    = 4;
    localparam int unsigned N_WR_PORTS  = 3;

    typedef struct packed {
        logic                   valid;
        logic [RF_LG_DEPTH-1:0] ptr;
        logic [RF_WIDTH-1:0]    data;
    } wb_req_t;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback request bus and RF write-side signals. Master = FU/RF side, slave = arbiter.
interface rf_wb_arbiter_if
    import rf_wb_pkg::*;
#(
    parameter int unsigned WIDTH    = RF_WIDTH,
    parameter int unsigned LG_DEPTH = RF_LG_DEPTH,
    parameter int unsigned N_REQ    = RF_N_REQ
);
    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ*LG_DEPTH-1:0] req_ptr;
    logic [N_REQ*WIDTH-1:0]    req_data;
    logic [N_REQ-1:0]          req_ready;

    logic                wen0, wen1, wen2;
    logic [LG_DEPTH-1:0] wrptr0, wrptr1, wrptr2;
    logic [WIDTH-1:0]    wr0, wr1, wr2;

    modport master (
        output req_valid, req_ptr, req_data,
        input  req_ready,
        input  wen0, wen1, wen2, wrptr0, wrptr1, wrptr2, wr0, wr1, wr2
    );

    modport slave (
        input  req_valid, req_ptr, req_data,
        output req_ready,
        output wen0, wen1, wen2, wrptr0, wrptr1, wrptr2, wr0, wr1, wr2
    );
endinterface

// File: rtl/rf_wb_pick.sv
// Find-first-set over an eligibility mask, scanning from a rotating start index.
module rf_wb_pick
    import rf_wb_pkg::*;
#(
    parameter  int unsigned N_REQ = RF_N_REQ,
    localparam int unsigned IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] elig,
    input  logic [IW-1:0]    start,
    output logic             found,
    output logic [IW-1:0]    idx
);
    int unsigned pos;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            pos = (32'(start) + k) % N_REQ;
            if (!found && elig[pos]) begin
                found = 1'b1;
                idx   = IW'(pos);
            end
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback scheduler: up to 3 grants/cycle onto registered RF write ports.
// Optional RF_WB_STATS_EN adds saturating stall_cnt / conflict_cnt outputs.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter  int unsigned WIDTH    = RF_WIDTH,
    parameter  int unsigned LG_DEPTH = RF_LG_DEPTH,
    parameter  int unsigned N_REQ    = RF_N_REQ,
    localparam int unsigned IW       = $clog2(N_REQ)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           hold,
    rf_wb_arbiter_if.slave bus,
    output logic [IW-1:0]  rr_ptr
`ifdef RF_WB_STATS_EN
    ,
    output logic [31:0]    stall_cnt,
    output logic [31:0]    conflict_cnt
`endif
);
    logic [LG_DEPTH-1:0] ptr_a  [N_REQ];
    logic [WIDTH-1:0]    data_a [N_REQ];
    logic [N_REQ-1:0]    zero_acc, elig0, elig1, elig2, grant;
    logic                found0, found1, found2;
    logic [IW-1:0]       win0, win1, win2;
    logic                live;

    assign live = !hold && !reset;

    always_comb begin
        zero_acc = '0;
        elig0    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            ptr_a[i]    = bus.req_ptr[i*LG_DEPTH +: LG_DEPTH];
            data_a[i]   = bus.req_data[i*WIDTH +: WIDTH];
            zero_acc[i] = live && bus.req_valid[i] && (ptr_a[i] == '0);
            elig0[i]    = live && bus.req_valid[i] && (ptr_a[i] != '0);
        end
    end

    // Each later stage drops prior winners by ptr match, which also removes the winner itself.
    always_comb begin
        elig1 = '0;
        for (int unsigned i = 0; i < N_REQ; i++)
            elig1[i] = elig0[i] && !(found0 && ptr_a[i] == ptr_a[win0]);
    end

    always_comb begin
        elig2 = '0;
        for (int unsigned i = 0; i < N_REQ; i++)
            elig2[i] = elig1[i] && !(found1 && ptr_a[i] == ptr_a[win1]);
    end

    rf_wb_pick #(.N_REQ(N_REQ)) u_pick0 (.elig(elig0), .start(rr_ptr), .found(found0), .idx(win0));
    rf_wb_pick #(.N_REQ(N_REQ)) u_pick1 (.elig(elig1), .start(rr_ptr), .found(found1), .idx(win1));
    rf_wb_pick #(.N_REQ(N_REQ)) u_pick2 (.elig(elig2), .start(rr_ptr), .found(found2), .idx(win2));

    always_comb begin
        grant = '0;
        for (int unsigned i = 0; i < N_REQ; i++)
            grant[i] = (found0 && win0 == IW'(i)) || (found1 && win1 == IW'(i)) ||
                       (found2 && win2 == IW'(i));
    end

    assign bus.req_ready = grant | zero_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.wen0   <= 1'b0;
            bus.wen1   <= 1'b0;
            bus.wen2   <= 1'b0;
            bus.wrptr0 <= '0;
            bus.wrptr1 <= '0;
            bus.wrptr2 <= '0;
            bus.wr0    <= '0;
            bus.wr1    <= '0;
            bus.wr2    <= '0;
            rr_ptr     <= '0;
        end else begin
            bus.wen0 <= found0;
            bus.wen1 <= found1;
            bus.wen2 <= found2;
            if (found0) begin
                bus.wrptr0 <= ptr_a[win0];
                bus.wr0    <= data_a[win0];
            end
            if (found1) begin
                bus.wrptr1 <= ptr_a[win1];
                bus.wr1    <= data_a[win1];
            end
            if (found2) begin
                bus.wrptr2 <= ptr_a[win2];
                bus.wr2    <= data_a[win2];
            end
            if (found2)
                rr_ptr <= IW'(rr_next(32'(win2), N_REQ));
            else if (found1)
                rr_ptr <= IW'(rr_next(32'(win1), N_REQ));
            else if (found0)
                rr_ptr <= IW'(rr_next(32'(win0), N_REQ));
        end
    end

`ifdef RF_WB_STATS_EN
    logic [N_REQ-1:0] dup_ref;

    always_comb begin
        dup_ref = '0;
        for (int unsigned i = 0; i < N_REQ; i++)
            dup_ref[i] = elig0[i] && !grant[i] &&
                         ((found0 && ptr_a[i] == ptr_a[win0]) ||
                          (found1 && ptr_a[i] == ptr_a[win1]) ||
                          (found2 && ptr_a[i] == ptr_a[win2]));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt    <= '0;
            conflict_cnt <= '0;
        end else begin
            if (|(bus.req_valid & ~bus.req_ready) && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
            if (|dup_ref && conflict_cnt != '1)
                conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed + randomized self-checking bench for rf_wb_arbiter.
module tb_rf_wb_arbiter;
    import rf_wb_pkg::*;

    localparam int unsigned W = 64;
    localparam int unsigned D = 6;
    localparam int unsigned N = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               hold;
    logic [$clog2(N)-1:0] rr_ptr;
`ifdef RF_WB_STATS_EN
    logic [31:0] stall_cnt, conflict_cnt;
`endif

    rf_wb_arbiter_if #(.WIDTH(W), .LG_DEPTH(D), .N_REQ(N)) bus ();

    rf_wb_arbiter #(.WIDTH(W), .LG_DEPTH(D), .N_REQ(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .hold   (hold),
        .bus    (bus),
        .rr_ptr (rr_ptr)
`ifdef RF_WB_STATS_EN
        ,
        .stall_cnt    (stall_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    wb_req_t rq [N];

    always_comb begin
        bus.req_valid = '0;
        bus.req_ptr   = '0;
        bus.req_data  = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]       = rq[i].valid;
            bus.req_ptr[i*D +: D]  = rq[i].ptr;
            bus.req_data[i*W +: W] = rq[i].data;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] dat(input int i, input int ptr);
        return {16'hC0DE, 32'h0, 8'(i), 8'(ptr)};
    endfunction

    task automatic set4(input logic [3:0] v, input int p0, input int p1, input int p2, input int p3);
        int pp [4];
        pp[0] = p0; pp[1] = p1; pp[2] = p2; pp[3] = p3;
        for (int i = 0; i < 4; i++) begin
            rq[i].valid = v[i];
            rq[i].ptr   = D'(pp[i]);
            rq[i].data  = dat(i, pp[i]);
        end
    endtask

    // Random-phase model state
    logic [D-1:0] eptr [N_WR_PORTS];
    logic [W-1:0] edat [N_WR_PORTS];
    logic [W-1:0] exp_rf [2**D];
    logic [W-1:0] dut_rf [2**D];
    logic [N-1:0] exp_ready;
    logic [2:0]   wen_v;
    logic [D-1:0] wp [N_WR_PORTS];
    logic [W-1:0] wd [N_WR_PORTS];
    int           m_rr, ngr, last, n_exp_wr, n_dut_wr;
    logic         dup;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        hold  = 1'b0;
        set4(4'b1111, 5, 6, 7, 8);

        // Reset held 3 cycles with all requests valid
        repeat (3) begin
            tick();
            chk("rst_ready", bus.req_ready, 4'b0000);
            chk("rst_wen0", bus.wen0, 0);
            chk("rst_wen1", bus.wen1, 0);
            chk("rst_wen2", bus.wen2, 0);
            chk("rst_rr", rr_ptr, 0);
`ifdef RF_WB_STATS_EN
            chk("rst_stall", stall_cnt, 0);
`endif
        end
        reset = 1'b0;

        // Four valid, three ports
        #1 chk("t2_ready", bus.req_ready, 4'b0111);
        tick();
        chk("t2_wen0", bus.wen0, 1);
        chk("t2_wen1", bus.wen1, 1);
        chk("t2_wen2", bus.wen2, 1);
        chk("t2_wrptr0", bus.wrptr0, 5);
        chk("t2_wrptr1", bus.wrptr1, 6);
        chk("t2_wrptr2", bus.wrptr2, 7);
        chk("t2_wr0", bus.wr0, dat(0, 5));
        chk("t2_wr2", bus.wr2, dat(2, 7));
        chk("t2_rr", rr_ptr, 3);
        set4(4'b1000, 5, 6, 7, 8);
        #1 chk("t2b_ready", bus.req_ready, 4'b1000);
        tick();
        chk("t2b_wen0", bus.wen0, 1);
        chk("t2b_wrptr0", bus.wrptr0, 8);
        chk("t2b_wr0", bus.wr0, dat(3, 8));
        chk("t2b_wen1", bus.wen1, 0);
        chk("t2b_wen2", bus.wen2, 0);
        chk("t2b_wrptr1_keep", bus.wrptr1, 6);
        chk("t2b_rr", rr_ptr, 0);

        // x0 accept does not consume a port
        set4(4'b1111, 0, 9, 10, 11);
        #1 chk("t3_ready", bus.req_ready, 4'b1111);
        tick();
        chk("t3_wen0", bus.wen0, 1);
        chk("t3_wen1", bus.wen1, 1);
        chk("t3_wen2", bus.wen2, 1);
        chk("t3_wrptr0", bus.wrptr0, 9);
        chk("t3_wrptr1", bus.wrptr1, 10);
        chk("t3_wrptr2", bus.wrptr2, 11);
        chk("t3_wr1", bus.wr1, dat(2, 10));
        chk("t3_rr", rr_ptr, 0);

        // Same-cycle duplicate destination
        set4(4'b0011, 12, 12, 0, 0);
        #1 chk("t4_ready", bus.req_ready, 4'b0001);
        tick();
        chk("t4_wen0", bus.wen0, 1);
        chk("t4_wrptr0", bus.wrptr0, 12);
        chk("t4_wr0", bus.wr0, dat(0, 12));
        chk("t4_wen1", bus.wen1, 0);
        chk("t4_rr", rr_ptr, 1);
`ifdef RF_WB_STATS_EN
        chk("t4_conflict", conflict_cnt, 1);
        chk("t4_stall", stall_cnt, 2);
`endif
        set4(4'b0010, 0, 12, 0, 0);
        #1 chk("t4b_ready", bus.req_ready, 4'b0010);
        tick();
        chk("t4b_wen0", bus.wen0, 1);
        chk("t4b_wr0", bus.wr0, dat(1, 12));
        chk("t4b_rr", rr_ptr, 2);

        // Hold for two cycles, then resume from the same rr_ptr
        hold = 1'b1;
        set4(4'b1111, 20, 21, 22, 23);
        repeat (2) begin
            #1 chk("t5_hold_ready", bus.req_ready, 4'b0000);
            tick();
            chk("t5_hold_wen0", bus.wen0, 0);
            chk("t5_hold_wen1", bus.wen1, 0);
            chk("t5_hold_wen2", bus.wen2, 0);
            chk("t5_hold_rr", rr_ptr, 2);
        end
        hold = 1'b0;
        #1 chk("t5_ready", bus.req_ready, 4'b1101);
        tick();
        chk("t5_wrptr0", bus.wrptr0, 22);
        chk("t5_wrptr1", bus.wrptr1, 23);
        chk("t5_wrptr2", bus.wrptr2, 20);
        chk("t5_rr", rr_ptr, 1);
        set4(4'b0010, 0, 21, 0, 0);
        #1 chk("t5b_ready", bus.req_ready, 4'b0010);
        tick();
        chk("t5b_wrptr0", bus.wrptr0, 21);
        chk("t5b_wen1", bus.wen1, 0);
        chk("t5b_rr", rr_ptr, 2);
`ifdef RF_WB_STATS_EN
        chk("t5_stall", stall_cnt, 5);
        chk("t5_conflict", conflict_cnt, 1);
`endif

        // Idle cycle
        set4(4'b0000, 0, 0, 0, 0);
        #1 chk("idle_ready", bus.req_ready, 4'b0000);
        tick();
        chk("idle_wen0", bus.wen0, 0);
        chk("idle_rr", rr_ptr, 2);

        // Reset mid-operation drops the cycle's grants
        set4(4'b1111, 30, 31, 32, 33);
        reset = 1'b1;
        #1 chk("mrst_ready", bus.req_ready, 4'b0000);
        tick();
        chk("mrst_wen0", bus.wen0, 0);
        chk("mrst_wen2", bus.wen2, 0);
        chk("mrst_wrptr0", bus.wrptr0, 0);
        chk("mrst_rr", rr_ptr, 0);
        reset = 1'b0;
        #1 chk("mrst_after_ready", bus.req_ready, 4'b0111);
        tick();
        chk("mrst_after_wrptr2", bus.wrptr2, 32);
        chk("mrst_after_rr", rr_ptr, 3);

        // Randomized run against a scoreboard and RF images
        set4(4'b0000, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_rr = 0;
        n_exp_wr = 0;
        n_dut_wr = 0;
        for (int a = 0; a < 2**D; a++) begin
            exp_rf[a] = '0;
            dut_rf[a] = '0;
        end
        for (int i = 0; i < N_WR_PORTS; i++) begin
            eptr[i] = '0;
            edat[i] = '0;
        end

        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!rq[i].valid && $urandom_range(0, 3) != 0) begin
                    rq[i].valid = 1'b1;
                    rq[i].ptr   = D'($urandom_range(0, 15));
                    rq[i].data  = {$urandom, $urandom};
                end
            end
            hold = ($urandom_range(0, 15) == 0);
            #1;
            exp_ready = '0;
            ngr  = 0;
            last = 0;
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_rr + k) % N;
                if (rq[i].valid && !hold) begin
                    if (rq[i].ptr == '0) begin
                        exp_ready[i] = 1'b1;
                    end else if (ngr < N_WR_PORTS) begin
                        dup = 1'b0;
                        for (int j = 0; j < ngr; j++)
                            if (eptr[j] == rq[i].ptr) dup = 1'b1;
                        if (!dup) begin
                            exp_ready[i] = 1'b1;
                            eptr[ngr] = rq[i].ptr;
                            edat[ngr] = rq[i].data;
                            last = i;
                            ngr++;
                        end
                    end
                end
            end
            chk("rnd_ready", bus.req_ready, exp_ready);
            tick();
            wen_v = {bus.wen2, bus.wen1, bus.wen0};
            wp[0] = bus.wrptr0; wp[1] = bus.wrptr1; wp[2] = bus.wrptr2;
            wd[0] = bus.wr0;    wd[1] = bus.wr1;    wd[2] = bus.wr2;
            for (int k = 0; k < N_WR_PORTS; k++) begin
                chk("rnd_wen", wen_v[k], (k < ngr));
                chk("rnd_x0_write", (wen_v[k] === 1'b1) && (wp[k] == '0), 0);
                if (k < ngr) begin
                    chk("rnd_wrptr", wp[k], eptr[k]);
                    chk("rnd_wr", wd[k], edat[k]);
                    exp_rf[eptr[k]] = edat[k];
                    n_exp_wr++;
                end
                if (wen_v[k] === 1'b1) begin
                    dut_rf[wp[k]] = wd[k];
                    n_dut_wr++;
                end
            end
            if (ngr > 0) m_rr = (last + 1) % N;
            chk("rnd_rr", rr_ptr, m_rr);
            for (int i = 0; i < N; i++)
                if (rq[i].valid && exp_ready[i]) rq[i].valid = 1'b0;
        end
        hold = 1'b0;

        for (int a = 0; a < 2**D; a++)
            chk("rf_readback", dut_rf[a], exp_rf[a]);
        chk("write_count", n_dut_wr, n_exp_wr);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
